mag_sq_accum_axis: RTL
======================

# mag_sq_accum_axis

Multi-channel, AXI-Stream successor to the single-lane squared-magnitude stage in the CSI extractor. Computes |x|² = I² + Q² for NUM_CH parallel channels (antennas or subcarrier lanes), optionally averages 2^k consecutive samples per channel, and presents results on a back-pressured AXI-Stream master. Sits between the FFT/CSI demux and the CSI packetiser/DMA.

## Interface
- DATA_WIDTH, 16: signed width of each I and Q component.
- NUM_CH, 4: number of parallel channels per beat.
- MAX_ACC_LOG2, 8: largest supported accumulation length exponent.
- Derived: MAG_W = 2·DATA_WIDTH; ACC_W = MAG_W + MAX_ACC_LOG2.

- clk_in  in  1  single clock.
- rst_in  in  1  synchronous, active-high reset.
- s_axis_tdata  in  NUM_CH·2·DATA_WIDTH  channel c at bits [c·2DW +: 2DW]; within each channel Q is in the upper half and I in the lower half, both signed.
- s_axis_tvalid / s_axis_tlast  in  1 each.
- s_axis_tready  out  1.
- acc_len_log2_in  in  $clog2(MAX_ACC_LOG2+1)  k, the block length exponent (block = 2^k samples).
- mean_mode_in  in  1  0 = output sum, 1 = output sum >> k.
- m_axis_tdata  out  NUM_CH·ACC_W  channel c at bits [c·ACC_W +: ACC_W], unsigned.
- m_axis_tvalid / m_axis_tlast  out  1 each.
- m_axis_tuser  out  1  partial-block flag.
- m_axis_tready  in  1.

## Operation
- Pipeline: S0 registers the input; S1 registers I·I and Q·Q per channel as signed DW×DW products; S2 registers the unsigned MAG_W sum; S3 is the accumulator/output register. All channels run in lockstep.
- Width: the maximum |x|² is 2^(2DW−1), so it fits in MAG_W. The accumulator cannot overflow at ACC_W. No saturation logic is needed.
- Global advance: en = !m_axis_tvalid | m_axis_tready. s_axis_tready = en, which is a combinational path from m_axis_tready. When en = 0, every stage holds, including the valid bits.
- Valid bubbles propagate through the pipeline and never touch the accumulator or the counter.
- Block counter cnt (MAX_ACC_LOG2 bits, shared across channels):
  - On a valid S2 beat with cnt = 0: latch k_lat = min(acc_len_log2_in, MAX_ACC_LOG2) and mean_lat = mean_mode_in, then load acc ← mag.
  - Otherwise: acc ← acc + mag.
- Emit condition: cnt = 2^k_lat − 1, or the S2 beat carries tlast. On emit:
  - Output register ← acc (or acc >> k_lat if mean_lat), applied per channel.
  - m_axis_tvalid ← 1; m_axis_tlast ← the beat's tlast.
  - m_axis_tuser ← 1 if tlast forced the emit before cnt reached 2^k_lat − 1.
  - cnt ← 0.
- With no emit, cnt increments.
- Partial blocks in mean mode are still shifted by k_lat, not by the actual count. The packetiser uses tuser to detect them.
- Changes to k or mode mid-block take effect only at the next block start.
- k = 0 is pass-through: every sample emits, and tuser is always 0.
- m_axis_tvalid clears on a handshake with no new emit in the same cycle. An emit in the same cycle as a handshake reloads the register, so there is no gap.

## Timing
- Reset: all stage valids 0; cnt, acc, k_lat and mean_lat 0; m_axis_tdata, tvalid, tlast and tuser all 0. s_axis_tready is 1 in the first cycle after reset.
- Reset mid-operation discards any partial block and any in-flight samples. No output is produced for them.
- Latency for k = 0 with no stall: a sample accepted at edge t drives m_axis_tvalid high from edge t+3 (four register stages).
- For k > 0: the result appears at edge t_last+3, where t_last is the acceptance edge of the block's final sample.
- Throughput: one input beat per cycle whenever m_axis_tready = 1.
- Stall: m_axis_tdata, tlast and tuser stay stable while tvalid = 1 and tready = 0.

## Structure
- Package csi_pkg holds:
  - the default parameter values;
  - a function acc_width(dw, max_log2);
  - a typedef for the per-channel {i, q} pair.
- Sub-module mag_sq_lane: S1/S2 for one channel, with an enable input, the DSP-friendly squares and the registered sum. It is instantiated NUM_CH times under generate.
- The top level owns S0, the valid/tlast pipeline, the counter, the accumulators and the output register.

## Test plan
- k=0, sum mode, one channel fed (3,4), (−32768,−32768) and (0,−1), tready=1 → outputs 25, 2147483648 and 1, each 3 edges after acceptance, with tuser=0.
- k=2, mean mode, 8 beats all (10,0) on every channel → 2 outputs, each 100; tlast only on the beat that contained input tlast.
- k=3, sum mode, tlast on the 5th sample of (1,1) → one output of 10 with tuser=1 and tlast=1; cnt restarts cleanly on the next beat.
- Random m_axis_tready (50%) with continuous input at k=0 → the output sequence equals the reference model, with no drops or duplicates, and the payload is stable during stalls.
- rst_in asserted mid-block at k=4 after 7 samples, then 16 samples of (2,0) → exactly one output of 64, with no remnant of the aborted block.
- acc_len_log2_in changed from 1 to 2 mid-block → the current block completes at 2 samples, and the next block uses 4.

Source files
------------

// File: rtl/csi_pkg.sv
// Shared definitions for the squared-magnitude accumulator.
// Contents:
//   DEF_*        default parameter values
//   acc_width()  accumulator width for a component width and block exponent
//   iq_pair_t    per-channel {q, i} pair, Q in the upper half
package csi_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_MAX_ACC_LOG2 = 8;

  // |x|^2 needs 2*dw bits. Summing 2^max_log2 of them adds max_log2 bits.
  function automatic int acc_width(input int dw, input int max_log2);
    return 2 * dw + max_log2;
  endfunction

  typedef struct packed {
    logic signed [DEF_DATA_WIDTH-1:0] q;
    logic signed [DEF_DATA_WIDTH-1:0] i;
  } iq_pair_t;

endpackage

// File: rtl/mag_sq_lane.sv
// One channel of the squared-magnitude datapath (pipeline stages S1 and S2).
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   en_i          global advance; every register holds while it is low
//   i_i, q_i      signed components, registered S0 values from the top level
//   mag_o         registered unsigned I*I + Q*Q (S2)
module mag_sq_lane
  import csi_pkg::*;
#(
  parameter int DW = DEF_DATA_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] i_i,
  input  logic signed [DW-1:0] q_i,
  output logic [2*DW-1:0]      mag_o
);

  localparam int MAG_W = 2 * DW;

  logic signed [MAG_W-1:0] ii_d, qq_d, ii_q, qq_q;
  logic [MAG_W-1:0]        mag_d, mag_q;

  // Plain DW x DW signed squares so each one maps onto a single multiplier.
  // Sign extension is explicit so the product is evaluated at MAG_W bits.
  always_comb begin
    ii_d = $signed({{DW{i_i[DW-1]}}, i_i}) * $signed({{DW{i_i[DW-1]}}, i_i});
    qq_d = $signed({{DW{q_i[DW-1]}}, q_i}) * $signed({{DW{q_i[DW-1]}}, q_i});
  end

  // Both squares are non-negative and at most 2^(2DW-2), so the unsigned
  // sum fits in MAG_W without a carry out.
  always_comb begin
    mag_d = $unsigned(ii_q) + $unsigned(qq_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ii_q  <= '0;
      qq_q  <= '0;
      mag_q <= '0;
    end else if (en_i) begin
      ii_q  <= ii_d;
      qq_q  <= qq_d;
      mag_q <= mag_d;
    end
  end

  assign mag_o = mag_q;

endmodule

// File: rtl/mag_sq_accum_axis.sv
// Multi-channel |x|^2 = I^2 + Q^2 with optional 2^k block averaging, AXI-Stream
// in and out. The pipeline is S0 input register, S1/S2 per-lane squares and
// sum, and S3 accumulator/output register. All channels run in lockstep.
// Ports:
//   clk_in, rst_in     clock, synchronous active-high reset
//   s_axis_*           input stream; channel c at tdata[c*2DW +: 2DW], {Q, I}
//   acc_len_log2_in    block exponent k (clamped to MAX_ACC_LOG2)
//   mean_mode_in       0: emit the block sum, 1: emit sum >> k
//   m_axis_*           output stream; channel c at tdata[c*ACC_W +: ACC_W]
//   m_axis_tuser       block closed early by tlast
//
// Handshake: a beat moves on either side only when tvalid and tready are both
// high at a rising edge. The whole pipeline advances when the output register
// is empty or is being taken (en). s_axis_tready equals en, so it depends
// combinationally on m_axis_tready. While en is low every stage holds,
// including its valid bit, so the output payload is stable during a stall.
module mag_sq_accum_axis
  import csi_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int MAX_ACC_LOG2 = DEF_MAX_ACC_LOG2
) (
  input  logic                                                 clk_in,
  input  logic                                                 rst_in,
  input  logic [NUM_CH*2*DATA_WIDTH-1:0]                       s_axis_tdata,
  input  logic                                                 s_axis_tvalid,
  input  logic                                                 s_axis_tlast,
  output logic                                                 s_axis_tready,
  input  logic [$clog2(MAX_ACC_LOG2+1)-1:0]                    acc_len_log2_in,
  input  logic                                                 mean_mode_in,
  output logic [NUM_CH*acc_width(DATA_WIDTH, MAX_ACC_LOG2)-1:0] m_axis_tdata,
  output logic                                                 m_axis_tvalid,
  output logic                                                 m_axis_tlast,
  output logic                                                 m_axis_tuser,
  input  logic                                                 m_axis_tready
);

  localparam int MAG_W = 2 * DATA_WIDTH;
  localparam int ACC_W = acc_width(DATA_WIDTH, MAX_ACC_LOG2);
  localparam int IN_W  = NUM_CH * 2 * DATA_WIDTH;
  localparam int KW    = $clog2(MAX_ACC_LOG2 + 1);
  localparam int CW    = MAX_ACC_LOG2;
  localparam int MW    = MAX_ACC_LOG2 + 1;

  logic en;

  // S0 and the valid/tlast shadow pipeline that follows the lanes.
  logic            s0_valid_q, s0_last_q;
  logic [IN_W-1:0] s0_data_q;
  logic            s1_valid_q, s1_last_q;
  logic            s2_valid_q, s2_last_q;

  logic [MAG_W-1:0] mag [NUM_CH];

  // Block state, shared by all channels.
  logic [CW-1:0]    cnt_q;
  logic [KW-1:0]    k_lat_q;
  logic             mean_lat_q;
  logic [ACC_W-1:0] acc_q [NUM_CH];

  // Output register.
  logic [ACC_W-1:0] out_q [NUM_CH];
  logic             m_valid_q, m_last_q, m_user_q;

  // Next-state / combinational helpers.
  logic             block_start;
  logic [KW-1:0]    k_req, k_eff;
  logic             mean_eff;
  logic [MW-1:0]    last_idx;
  logic             blk_full;
  logic             emit;
  logic [ACC_W-1:0] acc_d [NUM_CH];
  logic [ACC_W-1:0] out_d [NUM_CH];

  assign en            = !m_valid_q || m_axis_tready;
  assign s_axis_tready = en;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    mag_sq_lane #(
      .DW (DATA_WIDTH)
    ) u_lane (
      .clk_i (clk_in),
      .rst_i (rst_in),
      .en_i  (en),
      .i_i   (s0_data_q[c*2*DATA_WIDTH +: DATA_WIDTH]),
      .q_i   (s0_data_q[c*2*DATA_WIDTH+DATA_WIDTH +: DATA_WIDTH]),
      .mag_o (mag[c])
    );
  end

  // A block starts whenever the counter is at zero. That beat samples k and the
  // mode, so any change mid-block only takes effect at the next block. The
  // freshly sampled k is used for the start beat itself, which makes k = 0
  // emit on every beat.
  always_comb begin
    block_start = (cnt_q == '0);
    k_req       = (acc_len_log2_in > KW'(MAX_ACC_LOG2)) ? KW'(MAX_ACC_LOG2)
                                                        : acc_len_log2_in;
    k_eff       = block_start ? k_req : k_lat_q;
    mean_eff    = block_start ? mean_mode_in : mean_lat_q;
    last_idx    = (MW'(1) << k_eff) - MW'(1);
    blk_full    = ({1'b0, cnt_q} == last_idx);
    emit        = s2_valid_q && (blk_full || s2_last_q);
  end

  // A partial block in mean mode is still shifted by the full k.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      acc_d[c] = block_start ? ACC_W'(mag[c]) : acc_q[c] + ACC_W'(mag[c]);
      out_d[c] = mean_eff ? (acc_d[c] >> k_eff) : acc_d[c];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s0_valid_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_data_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      cnt_q      <= '0;
      k_lat_q    <= '0;
      mean_lat_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_user_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        out_q[c] <= '0;
      end
    end else if (en) begin
      s0_valid_q <= s_axis_tvalid;
      s0_last_q  <= s_axis_tlast;
      s0_data_q  <= s_axis_tdata;
      s1_valid_q <= s0_valid_q;
      s1_last_q  <= s0_last_q;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;

      // en high means the output register is empty or being taken this edge,
      // so it is refilled by an emit or else cleared.
      m_valid_q <= emit;

      // Bubbles leave the block state untouched.
      if (s2_valid_q) begin
        if (block_start) begin
          k_lat_q    <= k_req;
          mean_lat_q <= mean_mode_in;
        end
        for (int c = 0; c < NUM_CH; c++) begin
          acc_q[c] <= acc_d[c];
        end
        if (emit) begin
          cnt_q    <= '0;
          m_last_q <= s2_last_q;
          m_user_q <= s2_last_q && !blk_full;
          for (int c = 0; c < NUM_CH; c++) begin
            out_q[c] <= out_d[c];
          end
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  always_comb begin
    m_axis_tdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_axis_tdata[c*ACC_W +: ACC_W] = out_q[c];
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;

endmodule
